datapath_seq_ctrl: RTL and testbench

Instruction sequencer that drives the 4-register datapath (regfile plus ALU). It accepts packed register-to-register instructions over a valid/ready handshake and buffers them in a small FIFO. Each instruction is issued as a fixed two-cycle pattern: write cycle, then gap cycle. It sits directly upstream of datapath, and its outputs connect 1:1 to datapath's wr/addr1/addr2/addr3/ALUControl.

---
 rtl/dp_ctrl_pkg.sv | 29 ++
 rtl/dp_instr_fifo.sv | 52 +++++
 rtl/datapath_seq_ctrl.sv | 81 ++++++++
 tb/tb_datapath_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared instruction format, op codes and FSM encoding for the datapath sequencer
package dp_ctrl_pkg;
  localparam int INSTR_W = 9;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int DST_MSB = 5;
  localparam int DST_LSB = 4;
  localparam int SRCA_MSB = 3;
  localparam int SRCA_LSB = 2;
  localparam int SRCB_MSB = 1;
  localparam int SRCB_LSB = 0;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b111;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP = 2'd2;
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
  } instr_t;
  function automatic logic is_write(input logic [2:0] op);
    return op != OP_NOP;
  endfunction
endpackage

// File: rtl/dp_instr_fifo.sv
// dp_instr_fifo: first-word-fall-through instruction FIFO with registered full/empty and level
module dp_instr_fifo
  import dp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [W-1:0]             o_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [AW:0] r_level, w_level_nxt;
  logic r_full, r_empty, w_push, w_pop;
  assign w_push = i_push && !r_full;
  assign w_pop = i_pop && !r_empty;
  assign w_rd_nxt = r_rd_ptr + AW'(1);
  assign w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      r_level <= w_level_nxt;
      r_full <= w_level_nxt == (AW+1)'(DEPTH);
      r_empty <= w_level_nxt == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
  // o_next lets the sequencer load the following entry on the same edge that pops the head
  assign o_head = r_mem[r_rd_ptr];
  assign o_next = r_mem[w_rd_nxt];
  assign o_full = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;
endmodule

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: issues buffered register-to-register instructions to the datapath
// as a fixed write/gap pair, counting retired instructions
module datapath_seq_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [8:0]             instr,
  output logic                   instr_ready,
  input  logic                   run,
  output logic                   wr,
  output logic [1:0]             addr1,
  output logic [1:0]             addr2,
  output logic [1:0]             addr3,
  output logic [2:0]             ALUControl,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       retired
);
  logic [1:0] r_state, w_state_nxt;
  logic [INSTR_W-1:0] w_head, w_next;
  logic w_full, w_empty, w_pop, w_more, w_load;
  instr_t w_src;
  logic r_wr;
  logic [1:0] r_addr1, r_addr2, r_addr3;
  logic [2:0] r_op;
  logic [CNT_W-1:0] r_retired;
  dp_instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (instr_valid),
    .i_pop  (w_pop),
    .i_data (instr),
    .o_head (w_head),
    .o_next (w_next),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(fifo_level)
  );
  assign w_pop = r_state == S_GAP;
  // another entry must remain once the current head is popped
  assign w_more = |fifo_level[$clog2(DEPTH):1] && run;
  assign w_state_nxt = r_state == S_IDLE  ? ((!w_empty && run) ? S_ISSUE : S_IDLE) :
                       r_state == S_ISSUE ? S_GAP :
                       w_more ? S_ISSUE : S_IDLE;
  assign w_load = w_state_nxt == S_ISSUE;
  assign w_src = instr_t'(r_state == S_GAP ? w_next : w_head);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr <= 1'b0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_addr3 <= '0;
      r_op <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr <= w_load && is_write(w_src.op);
      if (w_load) begin
        r_addr1 <= w_src.src_a;
        r_addr2 <= w_src.src_b;
        r_addr3 <= w_src.dst;
        r_op <= w_src.op;
      end
      if (w_pop) r_retired <= r_retired + CNT_W'(1);
    end
  end
  assign instr_ready = !w_full;
  assign wr = r_wr;
  assign addr1 = r_addr1;
  assign addr2 = r_addr2;
  assign addr3 = r_addr3;
  assign ALUControl = r_op;
  assign busy = r_state != S_IDLE;
  assign retired = r_retired;
endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb_datapath_seq_ctrl: scoreboard bench; stimulus queues expected issues, a monitor checks them
module tb_datapath_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  logic clk, rst, instr_valid, run, instr_ready, wr, busy;
  logic [8:0] instr;
  logic [1:0] addr1, addr2, addr3;
  logic [2:0] ALUControl;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0] retired;
  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  logic [7:0] rf [4];
  logic ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_val;
  logic mon_prev_issue, mon_prev_gap;
  logic [CNT_W-1:0] mon_ret;

  datapath_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .run(run), .wr(wr), .addr1(addr1), .addr2(addr2),
    .addr3(addr3), .ALUControl(ALUControl), .busy(busy), .fifo_level(fifo_level),
    .retired(retired)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    return op == 3'b000 ? a + b : op == 3'b001 ? a - b : op == 3'b010 ? a & b :
           op == 3'b011 ? a ^ b : 8'h00;
  endfunction

  // stand-in for the downstream regfile: commits on the edge that ends the wr cycle
  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_val;
    else if (wr) rf[addr3] <= alu(ALUControl, rf[addr1], rf[addr2]);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_prev_issue = 0;
      mon_prev_gap = 0;
      mon_ret = 0;
    end else begin
      if (mon_prev_gap) mon_ret = mon_ret + 1'b1;
      chk("mon_retired", retired, mon_ret);
      if (busy && !mon_prev_issue) begin
        if (exp_q.size() == 0) chk("mon_unexpected_issue", 1, 0);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("mon_wr", wr, e[8:6] != 3'b111);
          chk("mon_addr1", addr1, e[3:2]);
          chk("mon_addr2", addr2, e[1:0]);
          chk("mon_addr3", addr3, e[5:4]);
          chk("mon_op", ALUControl, e[8:6]);
        end
        mon_prev_issue = 1;
        mon_prev_gap = 0;
      end else if (busy) begin
        chk("mon_gap_wr", wr, 0);
        mon_prev_issue = 0;
        mon_prev_gap = 1;
      end else begin
        chk("mon_idle_wr", wr, 0);
        mon_prev_issue = 0;
        mon_prev_gap = 0;
      end
    end
  end

  task automatic load(input logic [1:0] a, input logic [7:0] v);
    ld_en = 1; ld_addr = a; ld_val = v;
    @(negedge clk);
    ld_en = 0;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [8:0] x, output int n);
    n = 0;
    instr_valid = 1;
    instr = x;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("send_timeout", 0, 1);
      instr_valid = 0;
    end else begin
      @(posedge clk);
      exp_q.push_back(x);
      @(negedge clk);
      instr_valid = 0;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((busy || fifo_level != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] old;
    rst = 1; instr_valid = 0; instr = 0; run = 0; ld_en = 0; ld_addr = 0; ld_val = 0;
    repeat (2) @(negedge clk);
    chk("rst_wr", wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_addr3", addr3, 0);
    rst = 0;
    load(0, 8'd9); load(1, 8'd5); load(2, 8'd3);
    // reset while the write is presented
    run = 1;
    send(9'b000_00_01_10, n);
    @(negedge clk);
    chk("mid_wr_before", wr, 1);
    rst = 1;
    #1;
    chk("mid_wr", wr, 0);
    chk("mid_retired", retired, 0);
    chk("mid_level", fifo_level, 0);
    chk("mid_ready", instr_ready, 1);
    chk("mid_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_no_write_r0", rf[0], 9);
    rst = 0;
    // single instruction latency
    send(9'b000_00_01_10, n);
    @(negedge clk);
    chk("single_wr", wr, 1);
    chk("single_addr1", addr1, 1);
    chk("single_addr2", addr2, 2);
    chk("single_addr3", addr3, 0);
    chk("single_op", ALUControl, 0);
    @(negedge clk);
    chk("single_gap_wr", wr, 0);
    @(negedge clk);
    chk("single_busy", busy, 0);
    chk("single_retired", retired, 1);
    chk("single_r0", rf[0], 8);
    // four-instruction program, back to back
    load(1, 8'd5); load(2, 8'd3); load(3, 8'd6);
    send(9'b000_00_01_10, n);
    send(9'b010_01_10_11, n);
    send(9'b011_11_10_00, n);
    send(9'b001_10_01_11, n);
    wait_idle(n);
    chk("prog_cycles", n, 6);
    chk("prog_r0", rf[0], 8);
    chk("prog_r1", rf[1], 2);
    chk("prog_r3", rf[3], 11);
    chk("prog_retired", retired, 1);
    // FIFO full with run low
    run = 0;
    send(9'b000_01_00_00, n);
    send(9'b001_10_00_01, n);
    send(9'b010_11_01_10, n);
    send(9'b011_00_10_11, n);
    chk("full_ready", instr_ready, 0);
    chk("full_level", fifo_level, 4);
    chk("full_busy", busy, 0);
    instr_valid = 1;
    instr = 9'b100_01_11_10;
    repeat (3) @(negedge clk);
    chk("full_5th_rejected", fifo_level, 4);
    chk("full_wr", wr, 0);
    run = 1;
    send(9'b100_01_11_10, n);
    chk("full_accept_delay", n, 3);
    wait_idle(n);
    chk("full_retired", retired, 2);
    // pause during the second of three
    run = 0;
    send(9'b000_00_00_01, n);
    send(9'b001_01_10_11, n);
    send(9'b010_10_11_00, n);
    run = 1;
    repeat (3) @(negedge clk);
    chk("pause_issue2_busy", busy, 1);
    run = 0;
    repeat (2) @(negedge clk);
    chk("pause_busy", busy, 0);
    chk("pause_level", fifo_level, 1);
    chk("pause_retired", retired, 0);
    @(negedge clk);
    chk("pause_hold_level", fifo_level, 1);
    run = 1;
    wait_idle(n);
    chk("pause_end_retired", retired, 1);
    // NOP
    old = rf[1];
    send(9'b111_01_10_11, n);
    @(negedge clk);
    chk("nop_issue_wr", wr, 0);
    chk("nop_busy", busy, 1);
    @(negedge clk);
    chk("nop_gap_wr", wr, 0);
    wait_idle(n);
    chk("nop_retired", retired, 2);
    chk("nop_r1_unchanged", rf[1], old);
    // counter wrap: five from reset on a 2-bit counter
    do_reset();
    send(9'b000_00_01_10, n);
    send(9'b111_00_00_00, n);
    send(9'b011_01_01_01, n);
    send(9'b001_10_00_11, n);
    send(9'b010_11_10_01, n);
    wait_idle(n);
    chk("wrap_retired", retired, 1);
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
